// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands in over valid/ready,
// registered result and branch flag out over valid/ready.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;

  modport master (
    output in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle integer/branch ops plus an optional
// iterative shift-add multiplier, behind a valid/ready request/result handshake.
module alu_seq #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_XOR  = 5'd2,  OP_OR   = 5'd3,
    OP_AND  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_MUL  = 5'd10,
    OP_BEQ  = 5'd16, OP_BNE  = 5'd17, OP_BLT  = 5'd18, OP_BGE  = 5'd19,
    OP_BLTU = 5'd20, OP_BGEU = 5'd21
  } op_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          state, state_n;
  logic            out_valid_q, out_valid_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            taken_q, taken_n;
  logic [SHW-1:0]  cnt_q, cnt_n;
  logic [XLEN-1:0] acc_q, acc_n;
  logic [XLEN-1:0] mcand_q, mcand_n;
  logic [XLEN-1:0] mplier_q, mplier_n;

  logic            accept;
  logic            is_mul;
  logic [XLEN-1:0] alu_res;
  logic            alu_taken;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] diff;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] acc_step;

  assign bus.in_ready     = !rst && (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.branch_taken = taken_q;

  assign shamt = bus.op2[SHW-1:0];
  assign diff  = bus.op1 - bus.op2;
  assign lt_s  = $signed(bus.op1) < $signed(bus.op2);
  assign lt_u  = bus.op1 < bus.op2;
  assign eq    = bus.op1 == bus.op2;

  // Undefined codes, and MUL with MUL_EN=0, yield op1 - op2.
  always_comb begin
    alu_res   = diff;
    alu_taken = 1'b0;
    is_mul    = 1'b0;
    case (bus.op)
      OP_ADD:  alu_res = bus.op1 + bus.op2;
      OP_SUB:  alu_res = diff;
      OP_XOR:  alu_res = bus.op1 ^ bus.op2;
      OP_OR:   alu_res = bus.op1 | bus.op2;
      OP_AND:  alu_res = bus.op1 & bus.op2;
      OP_SLL:  alu_res = bus.op1 << shamt;
      OP_SRL:  alu_res = bus.op1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.op1) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_MUL:  is_mul  = MUL_EN;
      OP_BEQ:  alu_taken = eq;
      OP_BNE:  alu_taken = !eq;
      OP_BLT:  alu_taken = lt_s;
      OP_BGE:  alu_taken = !lt_s;
      OP_BLTU: alu_taken = lt_u;
      OP_BGEU: alu_taken = !lt_u;
      default: ;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_n     = state;
    out_valid_n = out_valid_q && !bus.out_ready;
    result_n    = result_q;
    taken_n     = taken_q;
    cnt_n       = cnt_q;
    acc_n       = acc_q;
    mcand_n     = mcand_q;
    mplier_n    = mplier_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_n  = S_MUL;
            acc_n    = '0;
            cnt_n    = '0;
            mcand_n  = bus.op1;
            mplier_n = bus.op2;
          end else begin
            result_n    = alu_res;
            taken_n     = alu_taken;
            out_valid_n = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_n    = acc_step;
        mcand_n  = mcand_q << 1;
        mplier_n = mplier_q >> 1;
        cnt_n    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN-1)) begin
          result_n    = acc_step;
          taken_n     = 1'b0;
          out_valid_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state       <= state_n;
      out_valid_q <= out_valid_n;
      result_q    <= result_n;
      taken_q     <= taken_n;
      cnt_q       <= cnt_n;
      acc_q       <= acc_n;
      mcand_q     <= mcand_n;
      mplier_q    <= mplier_n;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: 32-bit instance with multiplier plus a
// 16-bit instance without it.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(32)) bus ();
  alu_seq_if #(.XLEN(16)) bus16 ();

  alu_seq #(.XLEN(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_seq #(.XLEN(16), .MUL_EN(1'b0)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct packed {
    logic [31:0] res;
    logic        tk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_on  = 1'b0;

  logic        held_valid = 1'b0;
  logic [31:0] held_res;
  logic        held_tk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    r = a - b;
    t = 1'b0;
    case (o)
      5'd0:  r = a + b;
      5'd2:  r = a ^ b;
      5'd3:  r = a | b;
      5'd4:  r = a & b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: r = a * b;
      5'd16: t = (a == b);
      5'd17: t = (a != b);
      5'd18: t = ($signed(a) < $signed(b));
      5'd19: t = ($signed(a) >= $signed(b));
      5'd20: t = (a < b);
      5'd21: t = (a >= b);
      default: ;
    endcase
    return {t, r};
  endfunction

  // Called #1 after a rising edge; returns #1 after the acceptance edge
  // (or, for MUL, #1 after the edge that raises out_valid).
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic et);
    int unsigned w = 0;
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.op  = o;
    bus.op1 = a;
    bus.op2 = b;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{er, et});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op  = 5'($urandom);
    bus.op1 = $urandom;
    bus.op2 = $urandom;
    if (o == 5'd10) begin
      while (!bus.out_valid && n < 40) begin
        check_eq("mul_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        n++;
      end
      check_eq("mul_latency", n, 32);
    end else begin
      check_eq("latency1", bus.out_valid, 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_result", bus.result, held_res);
        check_eq("hold_taken", bus.branch_taken, held_tk);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", bus.out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", bus.result, e.res);
          check_eq("taken", bus.branch_taken, e.tk);
        end
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held_res   = bus.result;
      held_tk    = bus.branch_taken;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd11, 5'd31, 5'd15};
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0005};
    logic [32:0] m;
    logic [4:0]  o;
    logic [31:0] a, b;

    bus.in_valid = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.op = '0; bus16.op1 = '0; bus16.op2 = '0; bus16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_taken", bus.branch_taken, 0);
    check_eq("rst_in_ready16", bus16.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    send(5'd0,  32'hFFFF_FFFF, 32'h1,  32'h0000_0000, 1'b0);
    send(5'd7,  32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
    send(5'd6,  32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0);
    send(5'd5,  32'h1,         32'd31, 32'h8000_0000, 1'b0);
    send(5'd18, 32'hFFFF_FFFF, 32'h1,  32'hFFFF_FFFE, 1'b1);
    send(5'd20, 32'hFFFF_FFFF, 32'h1,  32'hFFFF_FFFE, 1'b0);
    send(5'd17, 32'd5,         32'd5,  32'h0,         1'b0);
    send(5'd10, 32'h0001_0003, 32'h5,  32'h0005_000F, 1'b0);
    send(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,  1'b0);

    // Consumer stall: first result must be held while the stream backs up.
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    fork
      begin
        send(5'd0, 32'd10,        32'd20,        32'd30,        1'b0);
        send(5'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
        send(5'd2, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFF00_FFFF, 1'b0);
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    send(5'd31, 32'd7, 32'd3, 32'd4, 1'b0);

    // Random traffic against the reference model with a jittering consumer.
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk);
        #1;
        if (rand_on) bus.out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 24; i++) begin
      o = ops[$urandom_range(0, 19)];
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      m = ref_alu(o, a, b);
      send(o, a, b, m[31:0], m[32]);
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;

    // Reset in the middle of a multiply must drop it without a result.
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.op = 5'd10; bus.op1 = 32'd1234; bus.op2 = 32'd77;
    @(negedge clk);
    check_eq("abort_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_out_valid", bus.out_valid, 0);
    check_eq("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(5'd0, 32'd2, 32'd2, 32'd4, 1'b0);

    // 16-bit instance without multiplier: MUL code behaves as illegal.
    bus16.in_valid = 1'b1; bus16.op = 5'd10; bus16.op1 = 16'd9; bus16.op2 = 16'd4;
    @(negedge clk);
    check_eq("m16_in_ready", bus16.in_ready, 1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    check_eq("m16_out_valid", bus16.out_valid, 1);
    check_eq("m16_result", bus16.result, 16'd5);
    check_eq("m16_taken", bus16.branch_taken, 0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
